// File: rtl/retire_stage.sv
// Retire stage: tracks per-ROB-slot completion, selects the in-order
// retiring prefix at the ROB head, drives free-list and architectural map
// updates, and latches a halted state when a halt instruction retires.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RUN   | normal retirement
// S_HALTED| a halt retired; retirement frozen until reset
module retire_stage #(
    parameter int N         = 3,
    parameter int ROB_SZ    = 32,
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    localparam int CB = $clog2(N + 1),
    localparam int RB = $clog2(ROB_SZ),
    localparam int PB = $clog2(PHYS_REGS),
    localparam int AB = $clog2(ARCH_REGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [RB-1:0]   i_rob_head,
    input  logic [CB-1:0]   i_rob_outputs_valid,
    input  logic [N*PB-1:0] i_rob_t_new,
    input  logic [N*PB-1:0] i_rob_t_old,
    input  logic [N*AB-1:0] i_rob_dest,
    input  logic [N-1:0]    i_rob_has_dest,
    input  logic [N-1:0]    i_rob_halt,
    input  logic [RB-1:0]   i_disp_tail,
    input  logic [CB-1:0]   i_disp_count,
    input  logic [N-1:0]    i_cdb_valid,
    input  logic [N*RB-1:0] i_cdb_rob_idx,
    output logic [CB-1:0]   o_num_retiring,
    output logic [N-1:0]    o_free_valid,
    output logic [N*PB-1:0] o_free_preg,
    output logic [N-1:0]    o_amap_we,
    output logic [N*AB-1:0] o_amap_idx,
    output logic [N*PB-1:0] o_amap_preg,
    output logic            o_halted,
    output logic [63:0]     o_retired_count
);

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    logic [0:0]        r_state;
    logic [ROB_SZ-1:0] r_complete;
    logic [63:0]       r_retired_count;

    logic [ROB_SZ-1:0] w_complete_next;
    logic [RB-1:0]     w_slot_idx [N];
    logic [CB-1:0]     w_num_retiring;
    logic              w_go;
    logic              w_halt_retiring;
    logic              w_wr;

    assign o_halted        = (r_state == S_HALTED);
    assign o_retired_count = r_retired_count;
    assign o_num_retiring  = w_num_retiring;

    // Longest complete prefix at the head, cut just after the first halt.
    always_comb begin
        w_num_retiring  = '0;
        w_go            = (r_state == S_RUN);
        w_halt_retiring = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_slot_idx[i] = i_rob_head + RB'(i);
            if (w_go && (CB'(i) < i_rob_outputs_valid) && r_complete[w_slot_idx[i]]) begin
                w_num_retiring = w_num_retiring + CB'(1);
                if (i_rob_halt[i]) begin
                    w_go            = 1'b0;
                    w_halt_retiring = 1'b1;
                end
            end else begin
                w_go = 1'b0;
            end
        end
    end

    // Per-slot free-list and architectural map updates; idle slots drive zero.
    always_comb begin
        o_free_valid = '0;
        o_free_preg  = '0;
        o_amap_we    = '0;
        o_amap_idx   = '0;
        o_amap_preg  = '0;
        w_wr         = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_wr = (CB'(i) < w_num_retiring) && i_rob_has_dest[i];
            if (w_wr) begin
                o_free_valid[i]         = 1'b1;
                o_free_preg[i*PB +: PB] = i_rob_t_old[i*PB +: PB];
                o_amap_we[i]            = 1'b1;
                o_amap_idx[i*AB +: AB]  = i_rob_dest[i*AB +: AB];
                o_amap_preg[i*PB +: PB] = i_rob_t_new[i*PB +: PB];
            end
        end
    end

    // Complete-vector update; later loops override earlier ones so dispatch
    // clear beats retire clear, which beats a CDB set on the same slot.
    always_comb begin
        w_complete_next = r_complete;
        for (int i = 0; i < N; i++) begin
            if (i_cdb_valid[i]) begin
                w_complete_next[i_cdb_rob_idx[i*RB +: RB]] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (CB'(i) < w_num_retiring) begin
                w_complete_next[w_slot_idx[i]] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (CB'(i) < i_disp_count) begin
                w_complete_next[i_disp_tail + RB'(i)] = 1'b0;
            end
        end
    end

    // Complete vector register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_complete <= '0;
        end else begin
            r_complete <= w_complete_next;
        end
    end

    // RUN/HALTED state machine; HALTED only leaves on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_RUN;
        end else if (r_state == S_RUN && w_halt_retiring) begin
            r_state <= S_HALTED;
        end
    end

    // Running count of retired instructions, wraps at 2^64.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_retired_count <= '0;
        end else begin
            r_retired_count <= r_retired_count + 64'(w_num_retiring);
        end
    end

endmodule

// File: tb/tb_retire_stage.sv
// Directed bench for retire_stage: completion latency, wrap-around,
// in-order prefix, halt behaviour, dispatch/retire/CDB priority and reset.
module tb_retire_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  head;
    logic [1:0]  valid;
    logic [17:0] t_new;
    logic [17:0] t_old;
    logic [14:0] dest;
    logic [2:0]  has_dest;
    logic [2:0]  halt;
    logic [4:0]  disp_tail;
    logic [1:0]  disp_count;
    logic [2:0]  cdb_v;
    logic [14:0] cdb_idx;

    logic [1:0]  num_ret;
    logic [2:0]  free_valid;
    logic [17:0] free_preg;
    logic [2:0]  amap_we;
    logic [14:0] amap_idx;
    logic [17:0] amap_preg;
    logic        halted;
    logic [63:0] retired;

    int n_pass  = 0;
    int n_total = 0;
    logic [4:0] h;

    retire_stage dut (
        .clock               (clock),
        .reset               (reset),
        .i_rob_head          (head),
        .i_rob_outputs_valid (valid),
        .i_rob_t_new         (t_new),
        .i_rob_t_old         (t_old),
        .i_rob_dest          (dest),
        .i_rob_has_dest      (has_dest),
        .i_rob_halt          (halt),
        .i_disp_tail         (disp_tail),
        .i_disp_count        (disp_count),
        .i_cdb_valid         (cdb_v),
        .i_cdb_rob_idx       (cdb_idx),
        .o_num_retiring      (num_ret),
        .o_free_valid        (free_valid),
        .o_free_preg         (free_preg),
        .o_amap_we           (amap_we),
        .o_amap_idx          (amap_idx),
        .o_amap_preg         (amap_preg),
        .o_halted            (halted),
        .o_retired_count     (retired)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1; head = 5'd0; valid = 2'd3; t_new = '0; t_old = '0; dest = '0;
        has_dest = '0; halt = '0; disp_tail = '0; disp_count = '0;
        cdb_v = 3'b111; cdb_idx = {5'd2, 5'd1, 5'd0};
        step();
        step();
        reset = 1'b0; cdb_v = '0;
        #1;
        chk("reset_num_ret", 64'(num_ret), 0);
        chk("reset_halted", 64'(halted), 0);
        chk("reset_retired", retired, 0);

        // completion visible one cycle after broadcast
        head = 5'd5; valid = 2'd1; has_dest = 3'b001;
        t_old = 18'd20; t_new = 18'd40; dest = 15'd7;
        cdb_v = 3'b001; cdb_idx = 15'd5;
        #1;
        chk("cdb_no_bypass", 64'(num_ret), 0);
        step();
        cdb_v = '0;
        #1;
        chk("cdb_next_cycle", 64'(num_ret), 1);
        chk("single_free_valid", 64'(free_valid), 64'h1);
        chk("single_free_preg", 64'(free_preg), 20);
        chk("single_amap_we", 64'(amap_we), 64'h1);
        chk("single_amap_idx", 64'(amap_idx), 7);
        chk("single_amap_preg", 64'(amap_preg), 40);
        step();
        chk("retired_slot_cleared", 64'(num_ret), 0);
        chk("retired_after_1", retired, 1);

        // wrap-around head at 30; ROB-empty outputs first
        valid = 2'd0; head = 5'd30; has_dest = 3'b111;
        t_old = {6'd12, 6'd11, 6'd10}; t_new = {6'd42, 6'd41, 6'd40};
        dest = {5'd9, 5'd8, 5'd7};
        cdb_v = 3'b111; cdb_idx = {5'd0, 5'd31, 5'd30};
        step();
        cdb_v = '0;
        #1;
        chk("empty_num_ret", 64'(num_ret), 0);
        chk("empty_free_valid", 64'(free_valid), 0);
        chk("empty_free_preg", 64'(free_preg), 0);
        chk("empty_amap_we", 64'(amap_we), 0);
        chk("empty_amap_idx", 64'(amap_idx), 0);
        chk("empty_amap_preg", 64'(amap_preg), 0);
        valid = 2'd3;
        #1;
        chk("wrap_num_ret", 64'(num_ret), 3);
        chk("wrap_free_valid", 64'(free_valid), 64'h7);
        chk("wrap_free_preg", 64'(free_preg), 64'({6'd12, 6'd11, 6'd10}));
        chk("wrap_amap_idx", 64'(amap_idx), 64'({5'd9, 5'd8, 5'd7}));
        chk("wrap_amap_preg", 64'(amap_preg), 64'({6'd42, 6'd41, 6'd40}));
        step();
        chk("wrap_cleared", 64'(num_ret), 0);
        chk("retired_after_4", retired, 4);

        // gap at slot 1 stops the prefix
        valid = 2'd0; head = 5'd0;
        cdb_v = 3'b011; cdb_idx = {5'd0, 5'd2, 5'd0};
        step();
        cdb_v = '0; valid = 2'd3; t_old = {6'd3, 6'd2, 6'd1};
        #1;
        chk("gap_num_ret", 64'(num_ret), 1);
        chk("gap_free_valid", 64'(free_valid), 64'h1);
        chk("gap_free_preg", 64'(free_preg), 1);
        chk("gap_amap_we", 64'(amap_we), 64'h1);
        step();
        chk("retired_after_5", retired, 5);

        // dispatch clear beats CDB set on the same slot
        valid = 2'd0; disp_tail = 5'd7; disp_count = 2'd1;
        cdb_v = 3'b001; cdb_idx = 15'd7;
        step();
        disp_count = '0; cdb_v = '0; head = 5'd7; valid = 2'd1; has_dest = 3'b001;
        #1;
        chk("disp_beats_cdb", 64'(num_ret), 0);
        step();
        chk("no_retire_without_cdb", 64'(num_ret), 0);
        cdb_v = 3'b001; cdb_idx = 15'd7;
        step();
        cdb_v = '0;
        #1;
        chk("retire_after_new_cdb", 64'(num_ret), 1);
        cdb_v = 3'b001; cdb_idx = 15'd7;
        step();
        cdb_v = '0;
        #1;
        chk("retire_beats_cdb", 64'(num_ret), 0);
        chk("retired_after_6", retired, 6);

        // dispatch of two slots wrapping 31 -> 0
        valid = 2'd0;
        cdb_v = 3'b011; cdb_idx = {5'd0, 5'd0, 5'd31};
        step();
        cdb_v = '0; head = 5'd31; valid = 2'd2;
        #1;
        chk("pre_wrap_disp_set", 64'(num_ret), 2);
        valid = 2'd0; disp_tail = 5'd31; disp_count = 2'd2;
        step();
        disp_count = '0; valid = 2'd2;
        #1;
        chk("wrap_disp_clear_31", 64'(num_ret), 0);
        head = 5'd0; valid = 2'd1;
        #1;
        chk("wrap_disp_clear_0", 64'(num_ret), 0);

        // steady retirement of three per round
        for (int r = 0; r < 11; r++) begin
            h = 5'(13 + 3 * r);
            valid = 2'd0;
            cdb_v = 3'b111; cdb_idx = {h + 5'd2, h + 5'd1, h};
            step();
            cdb_v = '0; valid = 2'd3; head = h;
            #1;
            chk("round_num_ret", 64'(num_ret), 3);
            step();
        end
        valid = 2'd0;
        cdb_v = 3'b001; cdb_idx = 15'd14;
        step();
        cdb_v = '0; valid = 2'd1; head = 5'd14;
        #1;
        chk("single_round", 64'(num_ret), 1);
        step();
        chk("retired_after_40", retired, 40);

        // halt in slot 1 truncates and freezes retirement
        valid = 2'd0;
        cdb_v = 3'b111; cdb_idx = {5'd22, 5'd21, 5'd20};
        step();
        cdb_v = '0; head = 5'd20; valid = 2'd3; halt = 3'b010; has_dest = 3'b000;
        #1;
        chk("halt_num_ret", 64'(num_ret), 2);
        chk("halt_no_dest_free", 64'(free_valid), 0);
        chk("halt_no_dest_amap", 64'(amap_we), 0);
        chk("halt_not_yet", 64'(halted), 0);
        step();
        halt = '0;
        chk("halted_set", 64'(halted), 1);
        chk("retired_after_42", retired, 42);
        head = 5'd22; valid = 2'd1;
        #1;
        chk("halted_blocks", 64'(num_ret), 0);
        cdb_v = 3'b001; cdb_idx = 15'd23;
        step();
        cdb_v = '0;
        step();
        valid = 2'd2;
        #1;
        chk("halted_still_blocks", 64'(num_ret), 0);
        chk("halted_absorbing", 64'(halted), 1);
        chk("halted_count_frozen", retired, 42);

        // reset while halted, with CDB activity in the reset cycle
        reset = 1'b1; cdb_v = 3'b001; cdb_idx = 15'd9;
        step();
        reset = 1'b0; cdb_v = '0;
        #1;
        chk("rst_halted_clear", 64'(halted), 0);
        chk("rst_retired_clear", retired, 0);
        for (int k = 0; k < 11; k++) begin
            head = 5'(3 * k); valid = 2'd3;
            #1;
            chk("rst_complete_clear", 64'(num_ret), 0);
        end
        step();
        chk("rst_retired_stays", retired, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/retire_stage.md
RETIRE_STAGE -- requirements
Module: retire_stage

Interface
REQ-001 Parameters SHALL be: N, 3, superscalar width; ROB_SZ, 32, ROB entries (power of 2); PHYS_REGS, 64, physical registers; ARCH_REGS, 32, architectural registers.
REQ-002 Derived widths SHALL be: CB = clog2(N+1) for counts; RB = clog2(ROB_SZ) for ROB indices; PB = clog2(PHYS_REGS) for physical registers; AB = clog2(ARCH_REGS) for architectural registers.
REQ-003 Clock and reset SHALL be: clock input 1, system clock; reset input 1, reset, synchronous, active-high.
REQ-004 ROB-side inputs SHALL be:
- rob_head input RB, ROB index of slot 0.
- rob_outputs_valid input CB, count of valid head entries (0..N).
- rob_t_new input N*PB, new physical destination per slot.
- rob_t_old input N*PB, previous physical mapping per slot.
- rob_dest input N*AB, architectural destination per slot.
- rob_has_dest input N, slot writes a register.
- rob_halt input N, slot is a halt instruction.
REQ-005 Dispatch and CDB inputs SHALL be:
- disp_tail input RB, ROB index receiving the first dispatched instruction.
- disp_count input CB, number of instructions dispatched this cycle.
- cdb_valid input N, completion broadcast valid per lane.
- cdb_rob_idx input N*RB, ROB index completing per lane.
REQ-006 Outputs SHALL be:
- num_retiring output CB, count returned to the ROB.
- free_valid output N, free-list release per slot.
- free_preg output N*PB, physical register to release.
- amap_we output N, architectural map write enable per slot.
- amap_idx output N*AB, architectural register written.
- amap_preg output N*PB, physical register written.
- halted output 1, processor halted.
- retired_count output 64, total instructions retired.

Function
REQ-007 The block SHALL hold a ROB_SZ-bit registered complete vector, one bit per ROB slot.
REQ-008 For each lane with cdb_valid set, complete[cdb_rob_idx] SHALL be set at the next clock edge.
- A completion is first visible to retirement one cycle after the broadcast, with no same-cycle bypass.
REQ-009 For i < disp_count, complete[(disp_tail+i) mod ROB_SZ] SHALL be cleared at the next edge, with wrap-around modulo ROB_SZ.
REQ-010 For i < num_retiring, complete[(rob_head+i) mod ROB_SZ] SHALL be cleared at the next edge.
REQ-011 Priority on the same index in the same cycle SHALL be: dispatch clear, then retire clear, then CDB set.
REQ-012 num_retiring SHALL be combinational and computed as follows:
- Count the longest prefix of slots i < rob_outputs_valid whose complete bit (at slot (rob_head+i) mod ROB_SZ) is set.
- Truncate the count immediately after the first slot with rob_halt set; the halt slot itself is included.
- Force the count to 0 while halted.
REQ-013 For each retiring slot i with rob_has_dest set:
- free_valid[i] = 1 and free_preg[i] = rob_t_old[i].
- amap_we[i] = 1, amap_idx[i] = rob_dest[i] and amap_preg[i] = rob_t_new[i].
REQ-014 Non-retiring slots and slots without a destination SHALL drive 0 on all of their output fields.
REQ-015 Slot order SHALL be preserved: the map table applies writes in increasing slot index, so the youngest write to the same architectural register wins.
REQ-016 The state machine SHALL have two states, RUN and HALTED:
- RUN to HALTED when a halt slot retires.
- HALTED is absorbing until reset.
- halted = 1 exactly when the state is HALTED, asserted the cycle after the halt retires.
REQ-017 retired_count SHALL increment by num_retiring each edge and wrap modulo 2^64.
REQ-018 When rob_outputs_valid = 0 (ROB empty), all outputs except halted and retired_count SHALL be 0.

Reset
REQ-019 On reset the block SHALL clear the complete vector to 0, enter RUN, set halted = 0 and set retired_count = 0.
REQ-020 Reset SHALL take priority over all same-cycle dispatch, CDB and retire activity, including reset asserted while halted or mid-retirement.
REQ-021 In the first cycle after reset, num_retiring SHALL be 0 regardless of rob_outputs_valid.

Verification
REQ-022 CDB on idx 5 at cycle t, rob_head = 5, rob_outputs_valid = 1 -> num_retiring = 0 at t and 1 at t+1.
REQ-023 Head at 30 with slots 30, 31 and 0 complete, all with destinations, t_old = 10, 11, 12 -> num_retiring = 3, free_preg = {10, 11, 12}, wrap-around verified.
REQ-024 Slots 0 and 2 complete, slot 1 incomplete -> num_retiring = 1, only free_valid[0] = 1.
REQ-025 Three complete slots with a halt in slot 1 -> num_retiring = 2, halted = 1 next cycle, num_retiring = 0 thereafter even with complete entries.
REQ-026 Same-cycle dispatch to idx 7 and CDB on idx 7 -> complete[7] = 0 next cycle, and a later retire at head 7 does not occur until a new CDB.
REQ-027 Reset asserted while halted with retired_count = 42 -> halted = 0, retired_count = 0, complete vector all 0 the next cycle.
